// File: rtl/gcn_transformation_ctrl.sv
// -----------------------------------------------------------------------------
// gcn_transformation_ctrl
//
// Sequencer for the GCN feature-transformation stage (FM x WM).
// For each weight column it reads the column from external memory and loads it
// into the weight scratch pad. It then walks every feature row, reading the
// row and strobing the FM_WM result memory. The combinational dot-product
// datapath thus fills the FEATURE_ROWS x WEIGHT_COLS product matrix.
//
// Ports:
//   clk                 clock, all state on rising edge
//   reset               asynchronous active-low reset
//   start               level request, sampled only in IDLE and DONE
//   read_address        FM/WM memory address, 0 whenever enable_read=0
//   enable_read         memory read strobe (data valid the following cycle)
//   enable_scratch_pad  scratch pad captures the weight column this edge
//   enable_write_fm_wm  FM_WM memory writes the dot product this edge
//   fm_wm_write_row     result row index (current feature row)
//   fm_wm_write_col     result column index (current weight column)
//   busy                high in every state except IDLE and DONE
//   done                high in DONE
// -----------------------------------------------------------------------------
module gcn_transformation_ctrl #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int WEIGHT_BASE           = 0,
  parameter int FEATURE_BASE          = 512,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [ADDRESS_WIDTH-1:0]         read_address,
  output logic                             enable_read,
  output logic                             enable_scratch_pad,
  output logic                             enable_write_fm_wm,
  output logic [COUNTER_FEATURE_WIDTH-1:0] fm_wm_write_row,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  fm_wm_write_col,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_W,
    S_LOAD_W,
    S_READ_F,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [COUNTER_FEATURE_WIDTH-1:0] r_row;
  logic [COUNTER_FEATURE_WIDTH-1:0] w_row_nxt;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  r_col;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  w_col_nxt;
  logic                             w_row_last;
  logic                             w_col_last;

  assign w_row_last = (r_row == COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1));
  assign w_col_last = (r_col == COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Next-state and Moore output decode; outputs depend only on r_state/r_row/r_col.
  always_comb begin
    w_state_nxt        = r_state;
    w_row_nxt          = r_row;
    w_col_nxt          = r_col;
    read_address       = '0;
    enable_read        = 1'b0;
    enable_scratch_pad = 1'b0;
    enable_write_fm_wm = 1'b0;
    busy               = 1'b1;
    done               = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_READ_W;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      S_READ_W: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(WEIGHT_BASE) + ADDRESS_WIDTH'(r_col);
        w_state_nxt  = S_LOAD_W;
      end
      S_LOAD_W: begin
        enable_scratch_pad = 1'b1;
        w_row_nxt          = '0;
        w_state_nxt        = S_READ_F;
      end
      S_READ_F: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(r_row);
        w_state_nxt  = S_WRITE;
      end
      S_WRITE: begin
        enable_write_fm_wm = 1'b1;
        if (!w_row_last) begin
          w_row_nxt   = r_row + 1'b1;
          w_state_nxt = S_READ_F;
        end else if (!w_col_last) begin
          w_col_nxt   = r_col + 1'b1;
          w_row_nxt   = '0;
          w_state_nxt = S_READ_W;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        // Hold until start drops so a held level cannot retrigger the sequence.
        if (!start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign fm_wm_write_row = r_row;
  assign fm_wm_write_col = r_col;

endmodule

// File: tb/tb_gcn_transformation_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gcn_transformation_ctrl
//
// Directed bench for gcn_transformation_ctrl: default 6x3 instance plus a
// 1x1 instance sharing the clock and reset.
// -----------------------------------------------------------------------------
module tb_gcn_transformation_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] read_address;
  logic        enable_read;
  logic        enable_scratch_pad;
  logic        enable_write_fm_wm;
  logic [2:0]  fm_wm_write_row;
  logic [1:0]  fm_wm_write_col;
  logic        busy;
  logic        done;

  logic        s_start;
  logic [12:0] s_read_address;
  logic        s_enable_read;
  logic        s_enable_scratch_pad;
  logic        s_enable_write_fm_wm;
  logic [0:0]  s_row;
  logic [0:0]  s_col;
  logic        s_busy;
  logic        s_done;

  int n_chk;
  int n_err;

  gcn_transformation_ctrl u_dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .read_address       (read_address),
    .enable_read        (enable_read),
    .enable_scratch_pad (enable_scratch_pad),
    .enable_write_fm_wm (enable_write_fm_wm),
    .fm_wm_write_row    (fm_wm_write_row),
    .fm_wm_write_col    (fm_wm_write_col),
    .busy               (busy),
    .done               (done)
  );

  gcn_transformation_ctrl #(
    .FEATURE_ROWS          (1),
    .WEIGHT_COLS           (1),
    .COUNTER_FEATURE_WIDTH (1),
    .COUNTER_WEIGHT_WIDTH  (1)
  ) u_small (
    .clk                (clk),
    .reset              (reset),
    .start              (s_start),
    .read_address       (s_read_address),
    .enable_read        (s_enable_read),
    .enable_scratch_pad (s_enable_scratch_pad),
    .enable_write_fm_wm (s_enable_write_fm_wm),
    .fm_wm_write_row    (s_row),
    .fm_wm_write_col    (s_col),
    .busy               (s_busy),
    .done               (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd"},   {31'd0, enable_read}, 0);
    chk({tag, ".addr"}, {19'd0, read_address}, 0);
    chk({tag, ".sp"},   {31'd0, enable_scratch_pad}, 0);
    chk({tag, ".wr"},   {31'd0, enable_write_fm_wm}, 0);
    chk({tag, ".row"},  {29'd0, fm_wm_write_row}, 0);
    chk({tag, ".col"},  {30'd0, fm_wm_write_col}, 0);
    chk({tag, ".busy"}, {31'd0, busy}, 0);
    chk({tag, ".done"}, {31'd0, done}, 0);
  endtask

  // Called just after the edge that accepted start (state READ_W).
  // Observes the 42 busy cycles, then checks done after edge 42.
  task automatic run_seq(input string tag, input bit hold, input bit glitch);
    int q[$];
    int exp_addr[$];
    int sp_cnt, wr_cnt, wbad, busy_bad, addr0_bad, strobe_bad;
    sp_cnt = 0; wr_cnt = 0; wbad = 0; busy_bad = 0; addr0_bad = 0; strobe_bad = 0;
    for (int j = 0; j < 3; j++) begin
      exp_addr.push_back(j);
      for (int i = 0; i < 6; i++) exp_addr.push_back(512 + i);
    end
    for (int c = 0; c < 42; c++) begin
      if (!hold && c == 0) start = 1'b0;
      if (glitch && c == 3) start = 1'b0;
      if (glitch && c == 5) start = 1'b1;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      if (int'(enable_read) + int'(enable_scratch_pad) + int'(enable_write_fm_wm) != 1)
        strobe_bad++;
      if (enable_read) q.push_back(int'(read_address));
      else if (read_address !== 13'd0) addr0_bad++;
      if (enable_scratch_pad) sp_cnt++;
      if (enable_write_fm_wm) begin
        if (int'(fm_wm_write_row) != wr_cnt % 6 || int'(fm_wm_write_col) != wr_cnt / 6) wbad++;
        wr_cnt++;
      end
      step();
    end
    chk({tag, ".n_reads"}, q.size(), 21);
    for (int k = 0; k < 21; k++) begin
      if (k < q.size()) chk($sformatf("%s.addr[%0d]", tag, k), q[k], exp_addr[k]);
    end
    chk({tag, ".sp_pulses"}, sp_cnt, 3);
    chk({tag, ".wr_pulses"}, wr_cnt, 18);
    chk({tag, ".wr_rowcol_bad"}, wbad, 0);
    chk({tag, ".busy_bad"}, busy_bad, 0);
    chk({tag, ".strobe_bad"}, strobe_bad, 0);
    chk({tag, ".addr_idle_bad"}, addr0_bad, 0);
    chk({tag, ".done"}, {31'd0, done}, 1);
    chk({tag, ".busy_end"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int found;
    int rd_cnt;
    n_chk = 0;
    n_err = 0;
    start   = 1'b1;
    s_start = 1'b0;
    reset   = 1'b0;

    // Reset held with start high: everything stays 0.
    repeat (5) step();
    chk_all_zero("reset");
    chk("small.reset.busy", {31'd0, s_busy}, 0);

    // Release reset; next edge enters READ_W with start still high.
    reset = 1'b1;
    step();
    chk("rel.rd", {31'd0, enable_read}, 1);
    chk("rel.addr", {19'd0, read_address}, 0);
    run_seq("seq1", 1'b0, 1'b0);
    step();
    chk("seq1.idle.done", {31'd0, done}, 0);
    chk("seq1.idle.busy", {31'd0, busy}, 0);

    // Done handshake: hold start through and past done.
    start = 1'b1;
    step();
    run_seq("seq2", 1'b1, 1'b0);
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (enable_read || done !== 1'b1) rd_cnt++;
    end
    chk("hold.done_stuck", rd_cnt, 0);
    start = 1'b0;
    step();
    chk("drop.done", {31'd0, done}, 0);
    chk("drop.rd", {31'd0, enable_read}, 0);
    step();
    chk("idle_stays.rd", {31'd0, enable_read}, 0);

    // Repeat with a start glitch during column 0.
    start = 1'b1;
    step();
    run_seq("seq3", 1'b1, 1'b1);
    start = 1'b0;
    step();

    // Mid-operation reset at WRITE of col=1,row=3.
    start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (enable_write_fm_wm && fm_wm_write_col == 2'd1 && fm_wm_write_row == 3'd3) found = 1;
      else step();
    end
    chk("midop.found", found, 1);
    reset = 1'b0;
    #1;
    chk_all_zero("midop_async");
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    chk("restart.rd", {31'd0, enable_read}, 1);
    chk("restart.addr", {19'd0, read_address}, 0);
    run_seq("seq4", 1'b0, 1'b0);
    step();

    // 1x1 instance: reads 0 then 512, one load, one write, done after 4 edges.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("small.c0.rd", {31'd0, s_enable_read}, 1);
    chk("small.c0.addr", {19'd0, s_read_address}, 0);
    step();
    chk("small.c1.sp", {31'd0, s_enable_scratch_pad}, 1);
    step();
    chk("small.c2.rd", {31'd0, s_enable_read}, 1);
    chk("small.c2.addr", {19'd0, s_read_address}, 512);
    step();
    chk("small.c3.wr", {31'd0, s_enable_write_fm_wm}, 1);
    chk("small.c3.rowcol", {30'd0, s_row, s_col}, 0);
    chk("small.c3.done", {31'd0, s_done}, 0);
    step();
    chk("small.c4.done", {31'd0, s_done}, 1);
    chk("small.c4.busy", {31'd0, s_busy}, 0);
    step();
    chk("small.idle.done", {31'd0, s_done}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
